sram_like_mem_slave: RTL and testbench

- Responder (slave) end of the SRAM-like request/handshake interface driven by the data cache's AXI-side port (req/wr/size/addr/wdata out; addr_ok/data_ok/rdata back).
- Models a word-organised memory with programmable access latency and a small in-order request queue.
- Used as the backing memory in cache-level benches and as a behavioural memory in SoC simulation.
- Supports byte, halfword and word writes, and full-word reads.

---
 rtl/sram_like_mem_slave.sv | 167 ++++++++++++++++
 tb/tb_sram_like_mem_slave.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_mem_slave.sv
// sram_like_mem_slave: responder end of the SRAM-like req/addr_ok/data_ok
// handshake. Word-organised memory, programmable latency, in-order queue.
// Optional: define SRAM_SLAVE_BACKPRESSURE_EN for LFSR-driven random stalls
// on addr_ok and on the latency countdown.
module sram_like_mem_slave #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3,
  parameter int QDEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int AW = ADDR_W + 2;  // word index plus byte offset

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [31:0]   mem     [2**ADDR_W];
  logic          q_wr    [QDEPTH];
  logic [1:0]    q_size  [QDEPTH];
  logic [AW-1:0] q_addr  [QDEPTH];
  logic [31:0]   q_wdata [QDEPTH];

  state_t        state, state_n;
  logic [LW-1:0] cnt, cnt_n;
  logic [PW-1:0] head, tail, head_n;
  logic [CW-1:0] count, count_pop, count_n;
  logic          push, pop, bp_gate, bp_hold;

  // Request being answered by the RESP cycle that starts at the next edge
  logic          t_wr;
  logic [1:0]    t_size;
  logic [AW-1:0] t_addr;
  logic [31:0]   t_wdata, t_old, t_new;
  logic [3:0]    t_mask;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^addr[31:AW];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Halfword at offset 3 shifts its upper lane out, leaving byte 3 only
  function automatic logic [3:0] byte_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

`ifdef SRAM_SLAVE_BACKPRESSURE_EN
  logic [15:0] lfsr;
  // Free-running x^16+x^14+x^13+x^11+1 LFSR for pseudo-random stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign bp_gate = lfsr[0];
  assign bp_hold = lfsr[1];
`else
  assign bp_gate = 1'b0;
  assign bp_hold = 1'b0;
`endif

  // Full test uses pre-pop count, so a full queue stalls even while retiring
  assign addr_ok   = req && (count < CW'(QDEPTH)) && !bp_gate;
  assign push      = addr_ok;
  assign pop       = (state == RESP);
  assign head_n    = pop ? ptr_inc(head) : head;
  assign count_pop = count - CW'(pop);
  assign count_n   = count_pop + CW'(push);

  // Pick the next head: if the queue drains this edge it is the incoming request
  always_comb begin
    t_wr    = wr;
    t_size  = size;
    t_addr  = addr[AW-1:0];
    t_wdata = wdata;
    if (count_pop != '0) begin
      t_wr    = q_wr[head_n];
      t_size  = q_size[head_n];
      t_addr  = q_addr[head_n];
      t_wdata = q_wdata[head_n];
    end
    t_mask = byte_mask(t_size, t_addr[1:0]);
    t_old  = mem[t_addr[AW-1:2]];
    t_new  = t_old;
    for (int b = 0; b < 4; b++)
      if (t_mask[b]) t_new[8*b +: 8] = t_wdata[8*b +: 8];
  end

  // Next-state: latency countdown per request, strictly one response at a time
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (push) begin
          if (LATENCY == 1) state_n = RESP;
          else begin state_n = WAIT; cnt_n = LW'(LATENCY - 1); end
        end
      end
      WAIT: begin
        if (!bp_hold) begin
          if (cnt <= LW'(1)) begin state_n = RESP; cnt_n = '0; end
          else cnt_n = cnt - LW'(1);
        end
      end
      RESP: begin
        if (count_n != '0) begin
          if (LATENCY == 1) state_n = RESP;
          else begin state_n = WAIT; cnt_n = LW'(LATENCY - 1); end
        end else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state, queue pointers and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      head    <= head_n;
      if (push) tail <= ptr_inc(tail);
      count   <= count_n;
      data_ok <= (state_n == RESP);
      rdata   <= (state_n == RESP) ? t_old : '0;
    end
  end

  // Queue payload storage; no reset needed, validity tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      q_wr[tail]    <= wr;
      q_size[tail]  <= size;
      q_addr[tail]  <= addr[AW-1:0];
      q_wdata[tail] <= wdata;
    end
  end

  // Write commits entering RESP, so the response carries the pre-write word
  always_ff @(posedge clk) begin
    if (rst && state_n == RESP && t_wr) mem[t_addr[AW-1:2]] <= t_new;
  end

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Bench for sram_like_mem_slave: directed scenarios plus randomized traffic,
// checked against a transaction-level memory/timing reference model.
module tb_sram_like_mem_slave;
  localparam int ADDR_W = 10;
  localparam int LAT    = 3;
  localparam int QD     = 2;

  logic clk = 1'b0, rst = 1'b0, req = 1'b0, wr = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic [31:0] addr  = '0, wdata = '0;
  logic [31:0] rdata;
  logic addr_ok, data_ok;

  sram_like_mem_slave #(.ADDR_W(ADDR_W), .LATENCY(LAT), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0, last_resp = -1000;

  typedef struct { int t; bit [31:0] d; } exp_t;
  typedef struct { bit wr; bit [1:0] sz; bit [31:0] a; bit [31:0] d; int gap; } rq_t;

  bit [31:0] mm [0:(1<<ADDR_W)-1];
  exp_t pend[$];
  rq_t  reqs[$];
  bit [31:0] got_rd[$];
  int got_t[$], acc_t[$];

  // Apply a sized write to a word: selected byte lanes only, no shifting
  function automatic bit [31:0] apply_wr(bit [31:0] old, bit [1:0] sz, bit [1:0] off, bit [31:0] d);
    bit [31:0] r = old;
    int lo = 0, hi = 3;
    if (sz == 2'd0) begin lo = off; hi = off; end
    else if (sz == 2'd1) begin lo = off; hi = (off == 2'd3) ? 3 : off + 1; end
    for (int b = lo; b <= hi; b++) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    pend.delete();
    last_resp = -1000;
  endtask

  // One cycle of the reference: in-order service, each response LAT cycles
  // after max(acceptance, previous response); state applied at acceptance.
  task automatic model_step(input bit r, input bit w, input bit [1:0] sz,
                            input bit [31:0] a, input bit [31:0] d,
                            output bit eaok, output bit edok, output bit [31:0] erd);
    exp_t e;
    int idx;
    edok = (pend.size() > 0) && (pend[0].t == cyc);
    erd  = edok ? pend[0].d : 32'h0;
    eaok = r && (pend.size() < QD);
    if (eaok) begin
      idx = int'((a >> 2) % (1 << ADDR_W));
      e.t = ((cyc > last_resp) ? cyc : last_resp) + LAT;
      e.d = mm[idx];
      last_resp = e.t;
      pend.push_back(e);
      if (w) mm[idx] = apply_wr(mm[idx], sz, a[1:0], d);
    end
    if (edok) void'(pend.pop_front());
    cyc++;
  endtask

  task automatic drive_tick(input bit r, input bit w, input bit [1:0] sz,
                            input bit [31:0] a, input bit [31:0] d,
                            output bit eaok, output bit edok, output bit [31:0] erd);
    @(posedge clk); #1;
    req = r; wr = w; size = sz; addr = a; wdata = d;
    @(negedge clk);
    model_step(r, w, sz, a, d, eaok, edok, erd);
  endtask

  // Issue reqs in order (req held until accepted), drain, compare every cycle
  task automatic test_traffic(input string nm);
    int i = 0, gap = 0, budget = 0;
    bit ea, ed, r;
    bit [31:0] er;
    rq_t q;
    got_rd.delete(); got_t.delete(); acc_t.delete();
    if (reqs.size() > 0) gap = reqs[0].gap;
    while ((i < reqs.size() || pend.size() > 0) && budget < 2000) begin
      q = '{1'b0, 2'b00, 32'h0, 32'h0, 0};
      if (i < reqs.size()) q = reqs[i];
      r = (i < reqs.size()) && (gap == 0);
      drive_tick(r, q.wr, q.sz, q.a, q.d, ea, ed, er);
      n_cmp++;
      if (addr_ok !== ea) begin
        n_bad++; $display("FAIL %s addr_ok cyc %0d: got %b want %b", nm, cyc-1, addr_ok, ea);
      end
      n_cmp++;
      if (data_ok !== ed) begin
        n_bad++; $display("FAIL %s data_ok cyc %0d: got %b want %b", nm, cyc-1, data_ok, ed);
      end
      if (ed) begin
        n_cmp++;
        if (rdata !== er) begin
          n_bad++; $display("FAIL %s rdata cyc %0d: got %h want %h", nm, cyc-1, rdata, er);
        end
        got_rd.push_back(rdata); got_t.push_back(cyc-1);
      end
      if (ea) begin
        acc_t.push_back(cyc-1); i++;
        gap = (i < reqs.size()) ? reqs[i].gap : 0;
      end else if (!r && gap > 0) gap--;
      budget++;
    end
    n_cmp++;
    if (budget >= 2000) begin
      n_bad++; $display("FAIL %s timeout: got %0d of %0d accepted", nm, i, reqs.size());
    end
    reqs.delete();
  endtask

  task automatic test_reset();
    bit ea, ed; bit [31:0] er;
    repeat (3) @(posedge clk);
    n_cmp++;
    if (data_ok !== 1'b0 || rdata !== 32'h0 || addr_ok !== 1'b0) begin
      n_bad++; $display("FAIL reset_hold: got %b/%h/%b want 0/0/0", data_ok, rdata, addr_ok);
    end
    @(negedge clk); rst = 1'b1; model_reset();
    for (int k = 0; k < 10; k++) begin
      drive_tick(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, ea, ed, er);
      n_cmp++;
      if (addr_ok !== 1'b0 || data_ok !== 1'b0 || rdata !== 32'h0) begin
        n_bad++; $display("FAIL idle %0d: got %b/%b/%h want 0/0/0", k, addr_ok, data_ok, rdata);
      end
    end
    // accept a read, then reset while it is still counting down
    drive_tick(1'b1, 1'b0, 2'b10, 32'h10, 32'h0, ea, ed, er);
    n_cmp++;
    if (addr_ok !== 1'b1) begin
      n_bad++; $display("FAIL prereset_accept: got %b want 1", addr_ok);
    end
    drive_tick(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, ea, ed, er);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (data_ok !== 1'b0 || rdata !== 32'h0) begin
      n_bad++; $display("FAIL async_reset: got %b/%h want 0/0", data_ok, rdata);
    end
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_tick(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, ea, ed, er);
      n_cmp++;
      if (data_ok !== 1'b0) begin
        n_bad++; $display("FAIL stale_data_ok %0d: got %b want 0", k, data_ok);
      end
    end
    reqs.push_back('{1'b0, 2'b10, 32'h10, 32'h0, 0});
    test_traffic("post_reset");
    n_cmp++;
    if (got_t.size() != 1 || acc_t.size() != 1 || got_t[0] - acc_t[0] != LAT) begin
      n_bad++; $display("FAIL post_reset_latency: got %0d responses want 1 at +%0d", got_t.size(), LAT);
    end
  endtask

  task automatic test_word();
    reqs.push_back('{1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 0});
    reqs.push_back('{1'b0, 2'b10, 32'h10, 32'h0, 4});
    test_traffic("word");
    n_cmp++;
    if (got_rd.size() != 2) begin
      n_bad++; $display("FAIL word_count: got %0d want 2", got_rd.size());
    end else begin
      n_cmp++;
      if (got_rd[1] !== 32'hDEADBEEF || got_t[0] - acc_t[0] != 3 || got_t[1] - acc_t[1] != 3) begin
        n_bad++; $display("FAIL word_read: got %h lat %0d/%0d want deadbeef lat 3/3",
                          got_rd[1], got_t[0] - acc_t[0], got_t[1] - acc_t[1]);
      end
    end
  endtask

  task automatic test_mask();
    bit [31:0] want [3] = '{32'h1122AA44, 32'hBBCCAA44, 32'hEECCAA44};
    reqs.push_back('{1'b1, 2'b10, 32'h20, 32'h11223344, 0});
    reqs.push_back('{1'b1, 2'b00, 32'h21, 32'h0000AA00, 0});
    reqs.push_back('{1'b0, 2'b10, 32'h20, 32'h0, 0});
    reqs.push_back('{1'b1, 2'b01, 32'h22, 32'hBBCC0000, 0});
    reqs.push_back('{1'b0, 2'b00, 32'h20, 32'h0, 0});
    reqs.push_back('{1'b1, 2'b01, 32'h23, 32'hEE000000, 0});
    reqs.push_back('{1'b0, 2'b01, 32'h22, 32'h0, 0});
    test_traffic("mask");
    n_cmp++;
    if (got_rd.size() != 7) begin
      n_bad++; $display("FAIL mask_count: got %0d want 7", got_rd.size());
    end else
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (got_rd[2*k+2] !== want[k]) begin
          n_bad++; $display("FAIL mask_read%0d: got %h want %h", k, got_rd[2*k+2], want[k]);
        end
      end
  endtask

  task automatic test_wr_rd_same();
    reqs.push_back('{1'b1, 2'b10, 32'h30, 32'h12345678, 0});
    reqs.push_back('{1'b0, 2'b10, 32'h30, 32'h0, 0});
    test_traffic("wr_rd_same");
    n_cmp++;
    if (got_rd.size() != 2 || got_rd[got_rd.size()-1] !== 32'h12345678) begin
      n_bad++; $display("FAIL wr_rd_same: got %0d resp last %h want 12345678",
                        got_rd.size(), got_rd[got_rd.size()-1]);
    end
  endtask

  task automatic test_alias();
    reqs.push_back('{1'b1, 2'b10, 32'h00001004, 32'hCAFEF00D, 0});
    reqs.push_back('{1'b0, 2'b10, 32'h00000004, 32'h0, 2});
    test_traffic("alias");
    n_cmp++;
    if (got_rd.size() != 2 || got_rd[got_rd.size()-1] !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL alias: got %0d resp last %h want cafef00d",
                        got_rd.size(), got_rd[got_rd.size()-1]);
    end
  endtask

  task automatic test_back_to_back();
    int want_acc [3] = '{0, 1, 4};
    int want_rsp [3] = '{3, 6, 9};
    bit [31:0] want_d [3] = '{32'hDEADBEEF, 32'hEECCAA44, 32'h12345678};
    reqs.push_back('{1'b0, 2'b10, 32'h10, 32'h0, 0});
    reqs.push_back('{1'b0, 2'b10, 32'h20, 32'h0, 0});
    reqs.push_back('{1'b0, 2'b10, 32'h30, 32'h0, 0});
    test_traffic("b2b");
    n_cmp++;
    if (got_rd.size() != 3 || acc_t.size() != 3) begin
      n_bad++; $display("FAIL b2b_count: got %0d/%0d want 3/3", got_rd.size(), acc_t.size());
    end else
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (acc_t[k] - acc_t[0] != want_acc[k] || got_t[k] - acc_t[0] != want_rsp[k] ||
            got_rd[k] !== want_d[k]) begin
          n_bad++; $display("FAIL b2b_%0d: got acc %0d rsp %0d data %h want %0d %0d %h", k,
                            acc_t[k] - acc_t[0], got_t[k] - acc_t[0], got_rd[k],
                            want_acc[k], want_rsp[k], want_d[k]);
        end
      end
  endtask

  task automatic test_random();
    bit [31:0] a;
    for (int k = 0; k < 8; k++)
      reqs.push_back('{1'b1, 2'b10, 32'h100 + 32'(4*k), $urandom, 0});
    for (int k = 0; k < 60; k++) begin
      a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3))
          + (32'($urandom_range(0, 3)) << 12);
      reqs.push_back('{1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0});
    end
    test_traffic("random");
    n_cmp++;
    if (got_rd.size() != 68) begin
      n_bad++; $display("FAIL random_count: got %0d want 68", got_rd.size());
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_mask();
    test_wr_rd_same();
    test_alias();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
